// File: rtl/sync_pkg.sv
// sync_pkg: shared helpers and depth limits for clock-domain pointer crossings.
package sync_pkg;
  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;
  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_t;
  function automatic ptr_t gray2bin(input ptr_t g, input int w);
    ptr_t b = '0;
    for (int i = w - 1; i >= 0; i--) b[i] = g[i] ^ ((i == w - 1) ? 1'b0 : b[i+1]);
    return b;
  endfunction
  function automatic ptr_t bin2gray(input ptr_t b, input int w);
    ptr_t m = (ptr_t'(1) << w) - ptr_t'(1);
    return (b ^ (b >> 1)) & m;
  endfunction
  // clearing the lowest set bit leaves something only if two or more bits differ
  function automatic logic hamming_gt1(input ptr_t a, input ptr_t b);
    ptr_t d = a ^ b;
    return |(d & (d - ptr_t'(1)));
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: per-bit multi-flop synchronizer with async active-low reset.
module sync_chain #(
  parameter int STAGES = 2,
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] ASYNC,
  output logic [W-1:0] SYNC
);
  logic [W-1:0] q [STAGES];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) for (int i = 0; i < STAGES; i++) q[i] <= '0;
    else begin
      q[0] <= ASYNC;
      for (int i = 1; i < STAGES; i++) q[i] <= q[i-1];
    end
  assign SYNC = q[STAGES-1];
endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: gray pointer synchronizer with binary decode, change pulse and step-error tracking.
module gray_ptr_sync
  import sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int ptr_adr = 4,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [ptr_adr-1:0]   ASYNC_GRAY,
  input  logic                 ERR_CLR,
  output logic [ptr_adr-1:0]   SYNC_GRAY,
  output logic [ptr_adr-1:0]   SYNC_BIN,
  output logic                 PTR_CHG,
  output logic                 STEP_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);
  generate
    if (NUM_STAGES < SYNC_MIN_STAGES || NUM_STAGES > SYNC_MAX_STAGES || ptr_adr < 2) begin : g_bad_cfg
      $error("gray_ptr_sync: NUM_STAGES must be 2..4 and ptr_adr at least 2");
    end
  endgenerate
  logic [ptr_adr-1:0] gray_q;
  logic err;
  sync_chain #(.STAGES(NUM_STAGES), .W(ptr_adr)) u_chain (
    .CLK(CLK),
    .RST(RST),
    .ASYNC(ASYNC_GRAY),
    .SYNC(SYNC_GRAY)
  );
  assign err = hamming_gt1(ptr_t'(SYNC_GRAY), ptr_t'(gray_q));
  // an error event in the same cycle as a clear wins and restarts the count at one
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      gray_q <= '0;
      SYNC_BIN <= '0;
      PTR_CHG <= 1'b0;
      STEP_ERR <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      gray_q <= SYNC_GRAY;
      SYNC_BIN <= ptr_adr'(gray2bin(ptr_t'(SYNC_GRAY), ptr_adr));
      PTR_CHG <= SYNC_GRAY != gray_q;
      STEP_ERR <= err | (STEP_ERR & ~ERR_CLR);
      ERR_CNT <= err ? (ERR_CLR ? ERR_CNT_W'(1) : (&ERR_CNT ? ERR_CNT : ERR_CNT + ERR_CNT_W'(1)))
                     : (ERR_CLR ? '0 : ERR_CNT);
    end
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: directed checks of gray_ptr_sync at depth 2 and depth 3.
module tb_gray_ptr_sync;
  logic clk = 1'b0;
  logic rst2, rst3, err_clr;
  logic [3:0] async_gray;
  logic [3:0] sg2, sb2, ec2, sg3, sb3, ec3;
  logic pc2, se2, pc3, se3;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
  always #5 clk = ~clk;
  gray_ptr_sync #(.NUM_STAGES(2), .ptr_adr(4), .ERR_CNT_W(4)) dut2 (
    .CLK(clk), .RST(rst2), .ASYNC_GRAY(async_gray), .ERR_CLR(err_clr),
    .SYNC_GRAY(sg2), .SYNC_BIN(sb2), .PTR_CHG(pc2), .STEP_ERR(se2), .ERR_CNT(ec2)
  );
  gray_ptr_sync #(.NUM_STAGES(3), .ptr_adr(4), .ERR_CNT_W(4)) dut3 (
    .CLK(clk), .RST(rst3), .ASYNC_GRAY(async_gray), .ERR_CLR(err_clr),
    .SYNC_GRAY(sg3), .SYNC_BIN(sb3), .PTR_CHG(pc3), .STEP_ERR(se3), .ERR_CNT(ec3)
  );
  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v = 4'(b);
    return v ^ (v >> 1);
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst2 = 1'b0; rst3 = 1'b0; err_clr = 1'b0; async_gray = 4'b1000;
    tick(3);
    chk("rst_sync_gray", 8'(sg2), 8'h0);
    chk("rst_sync_bin", 8'(sb2), 8'h0);
    chk("rst_ptr_chg", 8'(pc2), 8'h0);
    chk("rst_step_err", 8'(se2), 8'h0);
    chk("rst_err_cnt", 8'(ec2), 8'h0);
    rst2 = 1'b1;
    tick(1);
    chk("rel1_sync_gray", 8'(sg2), 8'h0);
    chk("rel1_ptr_chg", 8'(pc2), 8'h0);
    tick(1);
    chk("rel2_sync_gray", 8'(sg2), 8'h8);
    chk("rel2_ptr_chg", 8'(pc2), 8'h0);
    tick(1);
    chk("rel3_sync_bin", 8'(sb2), 8'hf);
    chk("rel3_ptr_chg", 8'(pc2), 8'h1);
    chk("rel3_step_err", 8'(se2), 8'h0);
    tick(1);
    chk("rel4_ptr_chg", 8'(pc2), 8'h0);
    // gray count 0..15 starting from the wrap 15 -> 0
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      async_gray = to_gray(i);
      for (int j = 0; j < 4; j++) begin
        tick(1);
        pulses += int'(pc2);
        if (j == 1) chk("cnt_bin_old", 8'(sb2), 8'((i + 15) % 16));
        if (j == 2) chk("cnt_bin_new", 8'(sb2), 8'(i));
      end
    end
    chk("cnt_pulses", 8'(pulses), 8'd16);
    chk("cnt_step_err", 8'(se2), 8'h0);
    chk("cnt_err_cnt", 8'(ec2), 8'h0);
    async_gray = 4'b0000;
    tick(4);
    async_gray = 4'b0011;
    tick(2);
    chk("ill_pre_step_err", 8'(se2), 8'h0);
    tick(1);
    chk("ill_step_err", 8'(se2), 8'h1);
    chk("ill_err_cnt", 8'(ec2), 8'h1);
    chk("ill_sync_bin", 8'(sb2), 8'h2);
    chk("ill_ptr_chg", 8'(pc2), 8'h1);
    tick(1);
    for (int i = 0; i < 19; i++) begin
      async_gray = (async_gray == 4'b0011) ? 4'b0000 : 4'b0011;
      tick(4);
      if (i == 13) chk("sat_err_cnt_15", 8'(ec2), 8'd15);
    end
    chk("sat_err_cnt", 8'(ec2), 8'd15);
    chk("sat_step_err", 8'(se2), 8'h1);
    tick(3);
    chk("sat_hold", 8'(ec2), 8'd15);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_step_err", 8'(se2), 8'h0);
    chk("clr_err_cnt", 8'(ec2), 8'h0);
    async_gray = 4'b0011;
    tick(4);
    chk("col_pre_cnt", 8'(ec2), 8'h1);
    async_gray = 4'b0000;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("col_step_err", 8'(se2), 8'h1);
    chk("col_err_cnt", 8'(ec2), 8'h1);
    tick(1);
    chk("col_hold_cnt", 8'(ec2), 8'h1);
    // depth-3 instance: latency, then an asynchronous reset mid-crossing
    rst3 = 1'b1;
    tick(2);
    async_gray = 4'b0001;
    tick(3);
    chk("d3_bin_e3", 8'(sb3), 8'h0);
    chk("d3_gray_e3", 8'(sg3), 8'h1);
    tick(1);
    chk("d3_bin_e4", 8'(sb3), 8'h1);
    chk("d3_chg_e4", 8'(pc3), 8'h1);
    async_gray = 4'b0011;
    tick(4);
    chk("d3_bin_2", 8'(sb3), 8'h2);
    async_gray = 4'b0010;
    tick(1);
    #2 rst3 = 1'b0;
    #1;
    chk("d3_rst_gray", 8'(sg3), 8'h0);
    chk("d3_rst_bin", 8'(sb3), 8'h0);
    chk("d3_rst_chg", 8'(pc3), 8'h0);
    tick(2);
    rst3 = 1'b1;
    tick(3);
    chk("d3_rel_chg_e3", 8'(pc3), 8'h0);
    chk("d3_rel_bin_e3", 8'(sb3), 8'h0);
    tick(1);
    chk("d3_rel_chg_e4", 8'(pc3), 8'h1);
    chk("d3_rel_bin_e4", 8'(sb3), 8'h3);
    chk("d3_rel_step_err", 8'(se3), 8'h0);
    chk("d3_rel_err_cnt", 8'(ec3), 8'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
